// File: rtl/cdce_spi_pkg.sv
// Shared constants, word layout and FSM encoding for the CDCE62005 SPI responder.
package cdce_spi_pkg;

  localparam int WORD_W = 32;
  localparam int DATA_W = 28;
  localparam int CMD_W  = 4;
  localparam int CNT_W  = 16;

  localparam logic [CMD_W-1:0] CMD_READ   = 4'hE;
  localparam logic [CMD_W-1:0] CMD_EEPROM = 4'hF;

  // One past a full frame, so over-long frames remain distinguishable.
  localparam logic [5:0] BIT_CNT_FULL = 6'd32;
  localparam logic [5:0] BIT_CNT_SAT  = 6'd33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } st_e;

  function automatic logic [5:0] bit_cnt_inc(input logic [5:0] cnt);
    return (cnt == BIT_CNT_SAT) ? cnt : cnt + 6'd1;
  endfunction

endpackage

// File: rtl/cdce_spi_responder_sync.sv
// Multi-flop synchronizer for one SPI pin, with registered rise/fall detection.
// level_o, rise_o and fall_o are mutually aligned.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      level_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/cdce_spi_responder.sv
// CDCE62005 SPI responder: LSB-first 32-bit frames, register model 0..NUM_REGS-1,
// EEPROM shadow, and MISO readback of a previously requested register.
module cdce_spi_responder
  import cdce_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_le,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [CMD_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_strobe,
  output logic [CMD_W-1:0]  wr_addr,
  output logic              eeprom_copy,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [CMD_W:0] NUM_REGS_W = (CMD_W + 1)'(NUM_REGS);
  localparam logic [7:0]     FLUSH_N    = 8'(SYNC_STAGES + 1);

  // Synchronized pins
  logic       clk_level_unused, clk_rise, clk_fall;
  logic       le_level, le_rise, le_fall;
  logic       mosi_level;
  logic [1:0] mosi_edge_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (spi_clk),
    .level_o(clk_level_unused),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (spi_le),
    .level_o(le_level),
    .rise_o (le_rise),
    .fall_o (le_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (spi_mosi),
    .level_o(mosi_level),
    .rise_o (mosi_edge_unused[0]),
    .fall_o (mosi_edge_unused[1])
  );

  // State
  st_e                st_q, st_d;
  logic               held_q, held_d;
  logic               armed_q;
  logic [7:0]         flush_q;
  logic [WORD_W-1:0]  sr_q;
  logic [5:0]         bit_cnt_q;
  logic [WORD_W-1:0]  tx_q;
  logic               pend_valid_q;
  logic [CMD_W-1:0]   pend_addr_q;
  logic [CMD_W-1:0]   wr_addr_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [DATA_W-1:0]  reg_q    [NUM_REGS];
  logic [DATA_W-1:0]  eeprom_q [NUM_REGS];

  // Decode of the shifted word
  logic [CMD_W-1:0]   cmd;
  logic [DATA_W-1:0]  data;
  logic               cmd_is_reg;
  logic               take_fall;
  logic               commit_ok;
  logic               rd_req;
  logic               frame_err_c;
  logic [WORD_W-1:0]  pend_word;

  assign cmd        = sr_q[CMD_W-1:0];
  assign data       = sr_q[WORD_W-1:CMD_W];
  assign cmd_is_reg = ({1'b0, cmd} < NUM_REGS_W);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    st_d        = st_q;
    held_d      = held_q;
    take_fall   = 1'b0;
    commit_ok   = 1'b0;
    frame_err_c = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (armed_q && (le_fall || held_q)) begin
          st_d      = ST_SHIFT;
          take_fall = 1'b1;
          held_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (le_rise) st_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        st_d = ST_IDLE;
        // A new frame may start while this one commits; remember it.
        if (le_fall) held_d = 1'b1;
        if (bit_cnt_q == BIT_CNT_FULL) commit_ok   = 1'b1;
        else                           frame_err_c = 1'b1;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign wr_strobe   = commit_ok && cmd_is_reg;
  assign eeprom_copy = commit_ok && (cmd == CMD_EEPROM);
  assign rd_req      = commit_ok && (cmd == CMD_READ);
  assign frame_err   = frame_err_c;

  always_comb begin
    pend_word = {{DATA_W{1'b0}}, pend_addr_q};
    if ({1'b0, pend_addr_q} < NUM_REGS_W) begin
      pend_word = {reg_q[pend_addr_q], pend_addr_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      held_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      held_q <= held_d;
    end
  end

  // After reset, frames are accepted only once the synchronized spi_le has
  // reflected a genuine high pin level rather than its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      if (flush_q != FLUSH_N)            flush_q <= flush_q + 8'd1;
      if (flush_q == FLUSH_N && le_level) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      wr_addr_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      if (take_fall) begin
        bit_cnt_q    <= '0;
        tx_q         <= pend_valid_q ? pend_word : '0;
        pend_valid_q <= 1'b0;
      end else if (st_q == ST_SHIFT && !le_level) begin
        if (clk_rise) begin
          sr_q      <= {mosi_level, sr_q[WORD_W-1:1]};
          bit_cnt_q <= bit_cnt_inc(bit_cnt_q);
        end
        if (clk_fall) tx_q <= tx_q >> 1;
      end
      if (rd_req) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= sr_q[2*CMD_W-1:CMD_W];
      end
      if (wr_strobe) wr_addr_q   <= cmd;
      if (commit_ok) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // NOTE: the register file and shadow are small and architecturally reset
  // to zero, so they live in a reset flop block rather than a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i]    <= '0;
        eeprom_q[i] <= '0;
      end
    end else begin
      if (wr_strobe) reg_q[cmd] <= data;
      if (eeprom_copy) begin
        for (int i = 0; i < NUM_REGS; i++) eeprom_q[i] <= reg_q[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < NUM_REGS_W) rd_data = reg_q[rd_addr];
  end

  assign spi_miso  = tx_q[0];
  assign wr_addr   = wr_addr_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/cdce_spi_responder.md
# cdce_spi_responder

SPI responder (slave) for the CDCE62005 configuration protocol; the device-side end of the clock-chip configuration link. It receives 32-bit LSB-first frames framed by `spi_le`, maintains a model of registers 0–8 and an EEPROM shadow, and returns register contents on `spi_miso` after a read command. It is used as the chip stand-in in board-level loopback and bench environments, and it shares `clk` with the configuration logic.

## Interface
Parameters:
- `SYNC_STAGES`, 2: number of synchronizer flops on `spi_clk`, `spi_le` and `spi_mosi`. Minimum 2.
- `NUM_REGS`, 9: number of modelled registers (addresses 0..NUM_REGS-1). Maximum 9.

Ports:
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_clk` in 1: SPI clock from the master. Asynchronous to `clk`. Frequency must be ≤ clk/8.
- `spi_le` in 1: frame enable, active low. High = idle.
- `spi_mosi` in 1: serial data from the master.
- `spi_miso` out 1: serial readback data to the master.
- `rd_addr` in 4: local register-file read address.
- `rd_data` out 28: combinational read of `reg[rd_addr]`. Returns 0 when `rd_addr` ≥ NUM_REGS.
- `wr_strobe` out 1: one-cycle pulse when a register write commits.
- `wr_addr` out 4: address of the last committed write.
- `eeprom_copy` out 1: one-cycle pulse when an EEPROM copy command commits.
- `frame_err` out 1: one-cycle pulse when a malformed frame is discarded.
- `frame_cnt` out 16: count of committed good frames. Wraps at 0xFFFF→0.

## Operation
- Word format (LSB is shifted first): `cmd = w[3:0]`, `data = w[31:4]`.
- Command decode, applied at frame end:
  - `cmd` 0x0..NUM_REGS-1: `reg[cmd] <= data`; pulse `wr_strobe`; `wr_addr <= cmd`.
  - `cmd` 0xE: read request. `pend_addr <= w[7:4]`; `pend_valid <= 1`.
  - `cmd` 0xF: `eeprom[i] <= reg[i]` for all i; pulse `eeprom_copy`.
  - Any other `cmd`: the frame is counted but has no other effect.
- Shift register: on every synchronized rising edge of `spi_clk` while `spi_le` = 0, `sr <= {mosi, sr[31:1]}` and `bit_cnt` increments. `bit_cnt` saturates at 33.
- Frame end is the synchronized rising edge of `spi_le`:
  - `bit_cnt` == 32: commit the decoded command and increment `frame_cnt`.
  - Any other `bit_cnt`: discard the frame, pulse `frame_err`, leave registers unchanged, leave `pend_valid` unchanged.
- Readback:
  - On the synchronized falling edge of `spi_le` with `pend_valid` = 1, load `tx <= {reg[pend_addr], pend_addr}` and clear `pend_valid`.
  - `pend_addr` ≥ NUM_REGS loads `{28'h0, pend_addr}`.
  - `spi_miso = tx[0]`. On each synchronized falling edge of `spi_clk` during a frame, `tx <= tx >> 1`.
  - When no read is pending, `tx` loads 0.
  - The readback frame is also decoded as a normal frame.
- State machine `st`:
  - IDLE → SHIFT on `spi_le` fall.
  - SHIFT → COMMIT on `spi_le` rise.
  - COMMIT → IDLE after one cycle; decode and pulses happen in this cycle.
  - A `spi_le` fall while in COMMIT is held and taken on the next cycle; it is never lost.

## Timing
- Input latency: SYNC_STAGES cycles, plus 1 cycle for edge detection.
- `wr_strobe`, `eeprom_copy` and `frame_err` assert SYNC_STAGES+2 cycles after the `spi_le` rising pin edge. Each is exactly one cycle wide.
- `rd_data` reflects a write on the cycle after `wr_strobe`.
- The first MISO bit is valid SYNC_STAGES+2 cycles after `spi_le` falls. Each later bit is valid SYNC_STAGES+2 cycles after the `spi_clk` falling pin edge, which is before the next master sampling rising edge given the ≤ clk/8 ratio.
- Reset values:
  - `spi_miso` 0; `tx` 0.
  - All pulse outputs 0; `wr_addr` 0; `frame_cnt` 0.
  - All `reg` and `eeprom` entries 0; `pend_valid` 0; `bit_cnt` 0; `st` IDLE.
  - Synchronizers reset to idle levels: `spi_le` 1, `spi_clk` 0, `spi_mosi` 0.
- Reset asserted mid-frame aborts the frame with no commit and no `frame_err`. After release, `spi_le` must be seen high before a new frame is accepted.

## Structure
- Shared package `cdce_spi_pkg`:
  - Command constants `CMD_READ = 4'hE` and `CMD_EEPROM = 4'hF`.
  - `WORD_W = 32`, `DATA_W = 28`.
  - The state enum.
- Sub-module `spi_pin_sync`: per-pin SYNC_STAGES synchronizer with rise/fall edge detect. Instantiated for `spi_clk`, `spi_le` and `spi_mosi` (the data pin's edges are unused).

## Test plan
- Write 0xE9400300 (cmd 0), then 0xE9400301 -> `wr_strobe` twice, `wr_addr` = 1, `rd_data`@0 = 0xE940030, `rd_data`@1 = 0xE940030, `frame_cnt` = 2.
- Write reg 6 = 0x04BE03E6, send read cmd 0x0000006E, then a 32-clock frame -> the 32 MISO bits sampled on rising edges equal 0x04BE03E6.
- Read cmd for address 0xA, then a read frame -> MISO returns 0x0000000A; no `frame_err`.
- Frame with 31 clocks, then one with 33 clocks -> two `frame_err` pulses; registers and `frame_cnt` unchanged.
- Write regs 0–6, send 0x0000001F -> `eeprom_copy` single pulse; shadow matches regs. A later reg write does not alter the shadow.
- Assert `rst_n` after 16 bits of a write, release, then send a full write frame -> only the second frame commits; `spi_miso` = 0 during reset.
